// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM-side signal bundle for sram_port_arbiter.
// A requester drives req/we/addr/wdata and holds them stable until gnt; a transfer is req & gnt on a clk_valid edge.
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_lock;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              sram_write_en;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_write_data;
    logic [DATA_W-1:0] sram_read_data;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_lock,
        output d_gnt, d_rvalid, d_rdata,
        output sram_write_en, sram_addr, sram_write_data,
        input  sram_read_data
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata, d_lock,
        input  d_gnt, d_rvalid, d_rdata,
        input  sram_write_en, sram_addr, sram_write_data,
        output sram_read_data
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Core/debug arbiter for a single-port SRAM with debug lock and starvation protection.
// Define SRAM_ARB_RR_EN for round-robin IDLE arbitration instead of core priority.
module sram_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic arst_n,
    input  logic clk_valid,
    sram_port_arbiter_if.slave bus,
    output logic locked
);
    typedef enum logic {IDLE, LOCKED_ST} state_t;

    state_t state_q, state_d;
    logic   c_gnt, d_gnt;
    logic   c_tag_q, d_tag_q;

`ifdef SRAM_ARB_RR_EN
    logic last_d_q;
`else
    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);
    logic [3:0] wait_q, wait_d;
`endif

    always_comb begin
        state_d = state_q;
        c_gnt   = 1'b0;
        d_gnt   = 1'b0;
        case (state_q)
            IDLE: begin
`ifdef SRAM_ARB_RR_EN
                // On a tie the port that did not win last time goes first.
                if (bus.c_req && bus.d_req) begin
                    c_gnt = last_d_q;
                    d_gnt = !last_d_q;
                end else begin
                    c_gnt = bus.c_req;
                    d_gnt = bus.d_req;
                end
`else
                c_gnt = bus.c_req && (wait_q < MAX_W);
                d_gnt = !c_gnt && bus.d_req;
`endif
                if (clk_valid && d_gnt && bus.d_lock) state_d = LOCKED_ST;
            end
            LOCKED_ST: begin
                // The release cycle may still carry a final debug transfer.
                d_gnt = bus.d_req;
                if (clk_valid && !bus.d_lock) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef SRAM_ARB_RR_EN
    always_comb begin
        wait_d = wait_q;
        if (!bus.d_req || d_gnt) wait_d = 4'd0;
        else if (wait_q < MAX_W) wait_d = wait_q + 4'd1;
    end
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            c_tag_q  <= 1'b0;
            d_tag_q  <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last_d_q <= 1'b0;
`else
            wait_q   <= 4'd0;
`endif
        end else if (clk_valid) begin
            state_q  <= state_d;
            c_tag_q  <= c_gnt && !bus.c_we;
            d_tag_q  <= d_gnt && !bus.d_we;
`ifdef SRAM_ARB_RR_EN
            if (c_gnt) last_d_q <= 1'b0;
            else if (d_gnt) last_d_q <= 1'b1;
`else
            wait_q   <= wait_d;
`endif
        end
    end

    assign bus.c_gnt = c_gnt;
    assign bus.d_gnt = d_gnt;
    assign locked    = (state_q == LOCKED_ST);

    assign bus.sram_write_en   = (c_gnt && bus.c_we) || (d_gnt && bus.d_we);
    assign bus.sram_addr       = c_gnt ? bus.c_addr  : (d_gnt ? bus.d_addr  : '0);
    assign bus.sram_write_data = c_gnt ? bus.c_wdata : (d_gnt ? bus.d_wdata : '0);

    assign bus.c_rvalid = c_tag_q;
    assign bus.d_rvalid = d_tag_q;
    assign bus.c_rdata  = c_tag_q ? bus.sram_read_data : '0;
    assign bus.d_rdata  = d_tag_q ? bus.sram_read_data : '0;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed plus randomized bench for sram_port_arbiter with an SRAM model and a transaction-level reference.
module tb_sram_port_arbiter;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic arst_n;
    logic clk_valid;
    logic locked;

    sram_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    sram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .clk_valid (clk_valid),
        .bus       (bus),
        .locked    (locked)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- SRAM macro model ----------------
    logic [7:0] sram_mem [256];
    logic [7:0] rd_v;
    always @(posedge clk) begin
        if (clk_valid) begin
            rd_v = sram_mem[bus.sram_addr];
            if (bus.sram_write_en) sram_mem[bus.sram_addr] = bus.sram_write_data;
            bus.sram_read_data <= rd_v;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [256];
    logic [7:0] exp_c_q[$];
    logic [7:0] exp_d_q[$];
    bit m_locked, m_pend_c, m_pend_d, m_last_d;
    int m_wait;
    bit eg_c, eg_d, c_took, d_took;
    logic obs_c_gnt, obs_d_gnt, obs_we;
    logic [7:0] obs_addr;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_pend_c = 0;
        m_pend_d = 0;
        m_last_d = 0;
        m_wait   = 0;
        exp_c_q.delete();
        exp_d_q.delete();
    endtask

    task automatic model_update();
        if (m_pend_c) void'(exp_c_q.pop_front());
        if (m_pend_d) void'(exp_d_q.pop_front());
        m_pend_c = c_took && !bus.c_we;
        m_pend_d = d_took && !bus.d_we;
        if (m_pend_c) exp_c_q.push_back(ref_mem[bus.c_addr]);
        if (m_pend_d) exp_d_q.push_back(ref_mem[bus.d_addr]);
        if (c_took && bus.c_we) ref_mem[bus.c_addr] = bus.c_wdata;
        if (d_took && bus.d_we) ref_mem[bus.d_addr] = bus.d_wdata;
        if (m_locked) begin
            if (!bus.d_lock) m_locked = 0;
        end else if (d_took && bus.d_lock) begin
            m_locked = 1;
        end
        if (!bus.d_req || d_took) m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait++;
        if (c_took) m_last_d = 0;
        else if (d_took) m_last_d = 1;
    endtask

    task automatic check_outputs();
        logic [7:0] ea, ew;
        chk("c_gnt", bus.c_gnt, eg_c);
        chk("d_gnt", bus.d_gnt, eg_d);
        chk("one_hot", bus.c_gnt & bus.d_gnt, 0);
        chk("sram_we", bus.sram_write_en, (eg_c && bus.c_we) || (eg_d && bus.d_we));
        ea = eg_c ? bus.c_addr  : (eg_d ? bus.d_addr  : 8'h00);
        ew = eg_c ? bus.c_wdata : (eg_d ? bus.d_wdata : 8'h00);
        chk("sram_addr", bus.sram_addr, ea);
        chk("sram_wdata", bus.sram_write_data, ew);
        chk("c_rvalid", bus.c_rvalid, m_pend_c);
        chk("d_rvalid", bus.d_rvalid, m_pend_d);
        chk("c_rdata", bus.c_rdata, (m_pend_c && exp_c_q.size() > 0) ? exp_c_q[0] : 8'h00);
        chk("d_rdata", bus.d_rdata, (m_pend_d && exp_d_q.size() > 0) ? exp_d_q[0] : 8'h00);
        chk("locked", locked, m_locked);
    endtask

    // ---------------- driver: one clock period, entered and left at negedge ----------------
    task automatic cycle();
        #1;
        if (m_locked) begin
            eg_c = 0;
            eg_d = bus.d_req;
        end else begin
`ifdef SRAM_ARB_RR_EN
            if (bus.c_req && bus.d_req) begin
                eg_c = m_last_d;
                eg_d = !m_last_d;
            end else begin
                eg_c = bus.c_req;
                eg_d = bus.d_req;
            end
`else
            eg_c = bus.c_req && (m_wait < MAX_WAIT);
            eg_d = !eg_c && bus.d_req;
`endif
        end
        obs_c_gnt = bus.c_gnt;
        obs_d_gnt = bus.d_gnt;
        obs_we    = bus.sram_write_en;
        obs_addr  = bus.sram_addr;
        check_outputs();
        @(posedge clk);
        c_took = eg_c && clk_valid;
        d_took = eg_d && clk_valid;
        if (clk_valid) model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = 8'h00; bus.c_wdata = 8'h00;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 8'h00; bus.d_wdata = 8'h00;
        bus.d_lock = 0;
        clk_valid = 1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] c_pat;
        int writes;
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = 8'(i * 7 + 3);
            ref_mem[i]  = 8'(i * 7 + 3);
        end
        sram_mem[8'h10] = 8'hA5;
        ref_mem[8'h10]  = 8'hA5;
        c_took = 0;
        d_took = 0;
        idle_inputs();
        model_reset();
        arst_n = 0;
        @(negedge clk);
        chk("rst_locked", locked, 0);
        chk("rst_c_rvalid", bus.c_rvalid, 0);
        chk("rst_d_rvalid", bus.d_rvalid, 0);
        chk("rst_c_rdata", bus.c_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        arst_n = 1;
        cycle();

        // core read of 0x10
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 8'h10;
        cycle();
        chk("tp1_gnt", obs_c_gnt, 1);
        bus.c_req = 0;
        #1;
        chk("tp1_rvalid", bus.c_rvalid, 1);
        chk("tp1_rdata", bus.c_rdata, 8'hA5);
        chk("tp1_d_rvalid", bus.d_rvalid, 0);
        cycle();

        // debug write then core read of the same address
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h20; bus.d_wdata = 8'h3C;
        cycle();
        chk("tp2_we", obs_we, 1);
        chk("tp2_addr", obs_addr, 8'h20);
        bus.d_req = 0;
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 8'h20;
        cycle();
        bus.c_req = 0;
        #1;
        chk("tp2_rdata", bus.c_rdata, 8'h3C);
        cycle();

        // both ports held: starvation counter forces debug on the 5th cycle
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 8'h11;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h12;
        for (int i = 0; i < 6; i++) begin
            cycle();
            c_pat[i] = obs_c_gnt;
        end
        chk("tp3_pattern", c_pat, 6'b101111);
        idle_inputs();
        cycle();

        // outstanding read across three invalid cycles
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 8'h10;
        cycle();
        bus.c_req = 0;
        clk_valid = 0;
        for (int i = 0; i < 3; i++) cycle();
        #1;
        chk("tp5_rvalid", bus.c_rvalid, 1);
        chk("tp5_rdata", bus.c_rdata, 8'hA5);
        clk_valid = 1;
        cycle();
        chk("tp5_drop", bus.c_rvalid, 0);

        // debug locked burst of three writes against a busy core
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 8'h30;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 8'h40; bus.d_wdata = 8'h77; bus.d_lock = 1;
        writes = 0;
        for (int i = 0; i < 12 && writes < 3; i++) begin
            cycle();
            if (d_took) begin
                writes++;
                bus.d_addr = bus.d_addr + 8'd1;
                bus.d_wdata = bus.d_wdata + 8'd1;
            end
        end
        chk("tp4_writes", writes, 3);
        #1;
        chk("tp4_locked", locked, 1);
        bus.d_req = 0; bus.d_lock = 0;
        cycle();
        chk("tp4_core_blocked", obs_c_gnt, 0);
        #1;
        chk("tp4_unlocked", locked, 0);
        cycle();
        chk("tp4_core_after", obs_c_gnt, 1);
        idle_inputs();
        cycle();

        // randomized traffic; requesters hold until granted
        c_took = 0;
        d_took = 0;
        for (int n = 0; n < 400; n++) begin
            if (!bus.c_req || c_took) begin
                bus.c_req = ($urandom_range(0, 2) != 0);
                bus.c_we = 1'($urandom_range(0, 1));
                bus.c_addr = 8'($urandom_range(0, 15));
                bus.c_wdata = 8'($urandom);
            end
            if (!bus.d_req || d_took) begin
                bus.d_req = ($urandom_range(0, 1) != 0);
                bus.d_we = 1'($urandom_range(0, 1));
                bus.d_addr = 8'($urandom_range(0, 15));
                bus.d_wdata = 8'($urandom);
            end
            if ($urandom_range(0, 9) == 0) bus.d_lock = !bus.d_lock;
            clk_valid = ($urandom_range(0, 4) != 0);
            cycle();
        end
        idle_inputs();
        cycle();
        cycle();

        // reset while locked with a debug read outstanding
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 8'h20; bus.d_lock = 1;
        cycle();
        #1;
        chk("tp6_pre_locked", locked, 1);
        chk("tp6_pre_rvalid", bus.d_rvalid, 1);
        arst_n = 0;
        model_reset();
        #1;
        chk("tp6_locked", locked, 0);
        chk("tp6_c_rvalid", bus.c_rvalid, 0);
        chk("tp6_d_rvalid", bus.d_rvalid, 0);
        chk("tp6_d_rdata", bus.d_rdata, 0);
        arst_n = 1;
        idle_inputs();
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 8'h10;
        cycle();
        chk("tp6_core_gnt", obs_c_gnt, 1);
        bus.c_req = 0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
